icache_refill_arbiter: RTL and testbench

- Parametrised successor to the per-core instruction-fetch arbiter. Shares one L2 refill port and one boot ROM among N_CORES I-caches.
- Adds line-aligned requests, full multi-word boot ROM line fills, and a runtime-selectable arbitration mode (round-robin or fixed priority).
- Sits between the per-core I-caches and the shared L2 / boot ROM.

---
 rtl/icache_refill_arbiter_if.sv | 46 ++++
 rtl/icache_refill_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_icache_refill_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_refill_arbiter_if.sv
// Purpose: bundles the core-side, L2-side and boot-ROM-side signals of the
//          I-cache refill arbiter into one interface.
// Modports:
//   slave  - the arbiter: takes i_* as inputs and drives o_*.
//   master - the environment (I-caches, L2, boot ROM): drives i_*, observes o_*.
// Signals:
//   i_core_req/i_core_addr/o_core_rdata/o_core_done - per-core refill port
//   i_prio_mode                                     - 0 round-robin, 1 fixed priority
//   o_l2_req/o_l2_addr/i_l2_rdata/i_l2_done         - shared L2 line port
//   i_boot_base/i_boot_size                         - boot ROM window
//   o_boot_req/o_boot_addr/i_boot_data/i_boot_valid - boot ROM word port
interface icache_refill_arbiter_if #(
  parameter int unsigned N_CORES     = 4,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned BLOCK_WIDTH = 256,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned BOOT_AW     = 12
);
  logic [N_CORES-1:0]                  i_core_req;
  logic [N_CORES-1:0][ADDR_WIDTH-1:0]  i_core_addr;
  logic [N_CORES-1:0][BLOCK_WIDTH-1:0] o_core_rdata;
  logic [N_CORES-1:0]                  o_core_done;
  logic                                i_prio_mode;
  logic                                o_l2_req;
  logic [ADDR_WIDTH-1:0]               o_l2_addr;
  logic [BLOCK_WIDTH-1:0]              i_l2_rdata;
  logic                                i_l2_done;
  logic [ADDR_WIDTH-1:0]               i_boot_base;
  logic [ADDR_WIDTH-1:0]               i_boot_size;
  logic                                o_boot_req;
  logic [BOOT_AW-1:0]                  o_boot_addr;
  logic [INSTR_WIDTH-1:0]              i_boot_data;
  logic                                i_boot_valid;

  modport slave (
    input  i_core_req, i_core_addr, i_prio_mode, i_l2_rdata, i_l2_done,
           i_boot_base, i_boot_size, i_boot_data, i_boot_valid,
    output o_core_rdata, o_core_done, o_l2_req, o_l2_addr, o_boot_req, o_boot_addr
  );

  modport master (
    output i_core_req, i_core_addr, i_prio_mode, i_l2_rdata, i_l2_done,
           i_boot_base, i_boot_size, i_boot_data, i_boot_valid,
    input  o_core_rdata, o_core_done, o_l2_req, o_l2_addr, o_boot_req, o_boot_addr
  );
endinterface

// File: rtl/icache_refill_arbiter.sv
// Purpose: shares one L2 refill port and one boot ROM among N_CORES I-caches.
//          Requests are line aligned; lines inside the boot ROM window are
//          filled word by word from the ROM, all others come from L2.
//          Arbitration is round-robin or fixed priority, chosen per grant.
// Ports:
//   i_clk - clock
//   i_rst - asynchronous active-high reset
//   bus   - icache_refill_arbiter_if.slave (core, L2 and boot ROM signals)
// Optional feature: define ICARB_COALESCE_EN to deliver a fetched line to every
//   other eligible core requesting the same line in the same cycle.
module icache_refill_arbiter #(
  parameter int unsigned N_CORES     = 4,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned BLOCK_WIDTH = 256,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned BOOT_AW     = 12
) (
  input logic                   i_clk,
  input logic                   i_rst,
  icache_refill_arbiter_if.slave bus
);

  localparam int unsigned WORDS       = BLOCK_WIDTH / INSTR_WIDTH;
  localparam int unsigned LINE_BYTES  = BLOCK_WIDTH / 8;
  localparam int unsigned OFF_W       = $clog2(LINE_BYTES);
  localparam int unsigned INSTR_BYTES = INSTR_WIDTH / 8;
  localparam int unsigned IDX_W       = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int unsigned K_W         = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << OFF_W;
  localparam logic [N_CORES-1:0]    ONE_HOT0  = N_CORES'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_BOOT_RD,
    S_BOOT_WAIT,
    S_L2_WAIT,
    S_DELIVER
  } state_t;

  state_t                              r_state;
  logic [IDX_W-1:0]                    r_rr_ptr;
  logic [N_CORES-1:0]                  r_served;
  logic [IDX_W-1:0]                    r_win;
  logic [ADDR_WIDTH-1:0]               r_line_addr;
  logic                                r_boot;
  logic [K_W-1:0]                      r_k;
  logic [BLOCK_WIDTH-1:0]              r_line;
  logic [N_CORES-1:0][BLOCK_WIDTH-1:0] r_core_rdata;
  logic [N_CORES-1:0]                  r_core_done;
  logic                                r_l2_req;
  logic [ADDR_WIDTH-1:0]               r_l2_addr;
  logic                                r_boot_req;
  logic [BOOT_AW-1:0]                  r_boot_addr;

  logic [N_CORES-1:0]    w_elig;
  logic                  w_any;
  logic [IDX_W-1:0]      w_win_rr;
  logic [IDX_W-1:0]      w_win_fp;
  logic [IDX_W-1:0]      w_win;
  logic [ADDR_WIDTH-1:0] w_win_line;
  logic [ADDR_WIDTH:0]   w_line_ext;
  logic [ADDR_WIDTH:0]   w_base_ext;
  logic [ADDR_WIDTH:0]   w_end_ext;
  logic                  w_in_boot;
  logic [ADDR_WIDTH-1:0] w_boot_off;
  logic [N_CORES-1:0]    w_coal;
  logic [N_CORES-1:0]    w_dmask;

  // A core that was just delivered is masked for one cycle so its still-high req is not re-granted
  assign w_elig = bus.i_core_req & ~r_served;
  assign w_any  = |w_elig;

  // Round-robin: first eligible index at or above rr_ptr, wrapping
  always_comb begin
    logic        found;
    int unsigned j;
    found    = 1'b0;
    j        = 0;
    w_win_rr = '0;
    for (int unsigned i = 0; i < N_CORES; i++) begin
      j = (32'(r_rr_ptr) + i) % N_CORES;
      if (!found && w_elig[j]) begin
        found    = 1'b1;
        w_win_rr = IDX_W'(j);
      end
    end
  end

  // Fixed priority: scan downward so the lowest eligible index is the last write
  always_comb begin
    w_win_fp = '0;
    for (int i = int'(N_CORES) - 1; i >= 0; i--) begin
      if (w_elig[i]) w_win_fp = IDX_W'(i);
    end
  end

  assign w_win      = bus.i_prio_mode ? w_win_fp : w_win_rr;
  assign w_win_line = bus.i_core_addr[w_win] & LINE_MASK;

  // Window test carried out one bit wider so base+size cannot wrap; size 0 matches nothing
  assign w_line_ext = {1'b0, w_win_line};
  assign w_base_ext = {1'b0, bus.i_boot_base};
  assign w_end_ext  = {1'b0, bus.i_boot_base} + {1'b0, bus.i_boot_size};
  assign w_in_boot  = (w_line_ext >= w_base_ext) && (w_line_ext < w_end_ext);

  assign w_boot_off = r_line_addr - bus.i_boot_base
                    + ADDR_WIDTH'(r_k) * ADDR_WIDTH'(INSTR_BYTES);

`ifdef ICARB_COALESCE_EN
  // Other eligible cores waiting on the same line ride along with the winner
  always_comb begin
    w_coal = '0;
    for (int unsigned j = 0; j < N_CORES; j++) begin
      w_coal[j] = w_elig[j] && ((bus.i_core_addr[j] & LINE_MASK) == r_line_addr);
    end
  end
`else
  assign w_coal = '0;
`endif

  assign w_dmask = w_coal | (ONE_HOT0 << r_win);

  // Control FSM with registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_served     <= '0;
      r_win        <= '0;
      r_line_addr  <= '0;
      r_boot       <= 1'b0;
      r_k          <= '0;
      r_line       <= '0;
      r_core_rdata <= '0;
      r_core_done  <= '0;
      r_l2_req     <= 1'b0;
      r_l2_addr    <= '0;
      r_boot_req   <= 1'b0;
      r_boot_addr  <= '0;
    end else begin
      r_core_done <= '0;
      r_boot_req  <= 1'b0;
      r_served    <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_win       <= w_win;
            r_line_addr <= w_win_line;
            r_boot      <= w_in_boot;
            r_state     <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (r_boot) begin
            r_k     <= '0;
            r_state <= S_BOOT_RD;
          end else begin
            r_l2_req  <= 1'b1;
            r_l2_addr <= r_line_addr;
            r_state   <= S_L2_WAIT;
          end
        end
        S_BOOT_RD: begin
          r_boot_req  <= 1'b1;
          r_boot_addr <= BOOT_AW'(w_boot_off);
          r_state     <= S_BOOT_WAIT;
        end
        S_BOOT_WAIT: begin
          if (bus.i_boot_valid) begin
            r_line[32'(r_k) * INSTR_WIDTH +: INSTR_WIDTH] <= bus.i_boot_data;
            if (r_k == K_W'(WORDS - 1)) begin
              r_state <= S_DELIVER;
            end else begin
              r_k     <= r_k + K_W'(1);
              r_state <= S_BOOT_RD;
            end
          end
        end
        S_L2_WAIT: begin
          if (bus.i_l2_done) begin
            r_line   <= bus.i_l2_rdata;
            r_l2_req <= 1'b0;
            r_state  <= S_DELIVER;
          end
        end
        S_DELIVER: begin
          for (int unsigned j = 0; j < N_CORES; j++) begin
            if (w_dmask[j]) r_core_rdata[j] <= r_line;
          end
          r_core_done <= w_dmask;
          r_served    <= w_dmask;
          r_rr_ptr    <= (r_win == IDX_W'(N_CORES - 1)) ? '0 : r_win + IDX_W'(1);
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_core_rdata = r_core_rdata;
  assign bus.o_core_done  = r_core_done;
  assign bus.o_l2_req     = r_l2_req;
  assign bus.o_l2_addr    = r_l2_addr;
  assign bus.o_boot_req   = r_boot_req;
  assign bus.o_boot_addr  = r_boot_addr;

endmodule

// File: tb/tb_icache_refill_arbiter.sv
// Purpose: directed self-checking bench for icache_refill_arbiter (4 cores,
//          256-bit lines, 32-bit boot words). Covers reset, L2 latency, fixed
//          priority, round-robin wrap, boot ROM fill, boot window edges,
//          ignored strobes, reset abort and same-line requests.
module tb_icache_refill_arbiter;

  localparam int unsigned NC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   l2_rises = 0;
  int   boot_pulses = 0;
  logic l2_prev = 1'b0;

  icache_refill_arbiter_if #(.N_CORES(NC), .ADDR_WIDTH(32), .BLOCK_WIDTH(256),
                             .INSTR_WIDTH(32), .BOOT_AW(12)) bus ();

  icache_refill_arbiter #(.N_CORES(NC), .ADDR_WIDTH(32), .BLOCK_WIDTH(256),
                          .INSTR_WIDTH(32), .BOOT_AW(12)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Count L2 request rising edges and boot read pulses
  always @(posedge clk) begin
    l2_prev <= bus.o_l2_req;
    if (bus.o_l2_req && !l2_prev) l2_rises <= l2_rises + 1;
    if (bus.o_boot_req) boot_pulses <= boot_pulses + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rom(input logic [11:0] off);
    return 32'hB007_0000 | 32'(off);
  endfunction

  // Wait for o_l2_req, hold lat cycles, pulse i_l2_done, return the delivery vector
  task automatic l2_serve(input logic [255:0] data, input int lat,
                          output logic [NC-1:0] done_v, output logic [31:0] addr);
    int t;
    t = 0;
    while (!bus.o_l2_req && t < 20) begin
      tick();
      t++;
    end
    chk("l2_req_seen", 256'(bus.o_l2_req), 256'(1));
    addr = bus.o_l2_addr;
    repeat (lat) begin
      tick();
      chk("no_early_done", 256'(bus.o_core_done), 256'(0));
    end
    bus.i_l2_rdata = data;
    bus.i_l2_done  = 1'b1;
    tick();
    bus.i_l2_done  = 1'b0;
    chk("l2_req_drop", 256'(bus.o_l2_req), 256'(0));
    chk("done_not_yet", 256'(bus.o_core_done), 256'(0));
    tick();
    done_v = bus.o_core_done;
  endtask

  logic [NC-1:0]  dv;
  logic [31:0]    av;
  logic [255:0]   d;
  logic [255:0]   exp_line;
  int             t;
  int             b0;
  int             l0;

  initial begin
    bus.i_core_req   = '0;
    bus.i_core_addr  = '0;
    bus.i_prio_mode  = 1'b0;
    bus.i_l2_rdata   = '0;
    bus.i_l2_done    = 1'b0;
    bus.i_boot_base  = '0;
    bus.i_boot_size  = '0;
    bus.i_boot_data  = '0;
    bus.i_boot_valid = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_l2_req",    256'(bus.o_l2_req),       256'(0));
    chk("rst_l2_addr",   256'(bus.o_l2_addr),      256'(0));
    chk("rst_boot_req",  256'(bus.o_boot_req),     256'(0));
    chk("rst_boot_addr", 256'(bus.o_boot_addr),    256'(0));
    chk("rst_done",      256'(bus.o_core_done),    256'(0));
    chk("rst_rdata",     256'(|bus.o_core_rdata),  256'(0));
    rst = 1'b0;
    tick();

    // Single L2 request from core 2, done after 5 cycles
    bus.i_core_addr[2] = 32'h8000_0044;
    bus.i_core_req[2]  = 1'b1;
    tick();
    chk("l2_lat_1", 256'(bus.o_l2_req), 256'(0));
    tick();
    chk("l2_lat_2", 256'(bus.o_l2_req), 256'(1));
    d = {8{32'hA5A5_0002}};
    l2_serve(d, 5, dv, av);
    chk("single_addr",   256'(av), 256'(32'h8000_0040));
    chk("single_done",   256'(dv), 256'(4'b0100));
    chk("single_rdata2", bus.o_core_rdata[2], d);
    chk("single_rdata0", bus.o_core_rdata[0], 256'(0));
    bus.i_core_req[2] = 1'b0;
    tick();
    chk("single_done_pulse", 256'(bus.o_core_done), 256'(0));

    // Fixed priority with rr_ptr at 3: core 1 must win over core 3
    bus.i_prio_mode    = 1'b1;
    bus.i_core_addr[1] = 32'h0000_0100;
    bus.i_core_addr[3] = 32'h0000_0300;
    bus.i_core_req[1]  = 1'b1;
    bus.i_core_req[3]  = 1'b1;
    l2_serve({8{32'h1111_1111}}, 1, dv, av);
    chk("fp_first_done", 256'(dv), 256'(4'b0010));
    chk("fp_first_addr", 256'(av), 256'(32'h100));
    bus.i_core_req[1] = 1'b0;
    l2_serve({8{32'h3333_3333}}, 1, dv, av);
    chk("fp_second_done", 256'(dv), 256'(4'b1000));
    chk("fp_second_addr", 256'(av), 256'(32'h300));
    bus.i_core_req[3] = 1'b0;
    bus.i_prio_mode   = 1'b0;

    // Round-robin with all cores requesting continuously: 0,1,2,3,0
    for (int i = 0; i < 4; i++) bus.i_core_addr[i] = 32'h4000_0000 + 32'(i) * 32'h40;
    bus.i_core_req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      d = {8{32'hC0DE_0000 + 32'(n)}};
      l2_serve(d, 2, dv, av);
      chk("rr_done",  256'(dv), 256'(4'b0001 << (n % 4)));
      chk("rr_addr",  256'(av), 256'(32'h4000_0000 + 32'(n % 4) * 32'h40));
      chk("rr_rdata", bus.o_core_rdata[n % 4], d);
    end
    bus.i_core_req = '0;
    tick(); tick(); tick();
    chk("rr_idle_after", 256'(bus.o_l2_req), 256'(0));

    // Strobes outside their wait states are ignored
    bus.i_l2_done    = 1'b1;
    bus.i_boot_valid = 1'b1;
    tick();
    bus.i_l2_done    = 1'b0;
    bus.i_boot_valid = 1'b0;
    tick(); tick();
    chk("ignored_done", 256'(bus.o_core_done), 256'(0));
    chk("ignored_l2",   256'(bus.o_l2_req),    256'(0));

    // Boot fill: core 0 fetches 0x24 from a 4 KiB ROM at 0
    bus.i_boot_base    = 32'h0;
    bus.i_boot_size    = 32'h1000;
    bus.i_core_addr[0] = 32'h24;
    bus.i_core_req[0]  = 1'b1;
    b0 = boot_pulses;
    l0 = l2_rises;
    exp_line = '0;
    for (int k = 0; k < 8; k++) begin
      t = 0;
      while (!bus.o_boot_req && t < 10) begin
        tick();
        t++;
      end
      chk("boot_req_seen", 256'(bus.o_boot_req),  256'(1));
      chk("boot_addr",     256'(bus.o_boot_addr), 256'(32'h20 + 32'(k) * 4));
      chk("boot_no_l2",    256'(bus.o_l2_req),    256'(0));
      exp_line[k*32 +: 32] = rom(12'(32'h20 + 32'(k) * 4));
      bus.i_boot_data = exp_line[k*32 +: 32];
      tick();
      chk("boot_req_pulse", 256'(bus.o_boot_req), 256'(0));
      tick();
      bus.i_boot_valid = 1'b1;
      tick();
      bus.i_boot_valid = 1'b0;
    end
    t = 0;
    while (bus.o_core_done == '0 && t < 10) begin
      tick();
      t++;
    end
    chk("boot_done",     256'(bus.o_core_done), 256'(4'b0001));
    chk("boot_rdata",    bus.o_core_rdata[0],   exp_line);
    chk("boot_pulses",   256'(boot_pulses - b0), 256'(8));
    chk("boot_l2_never", 256'(l2_rises - l0),    256'(0));
    bus.i_core_req[0] = 1'b0;
    tick();

    // Boot window upper edge: 0x1100 is just past base 0x1000 + 0x100
    bus.i_boot_base    = 32'h1000;
    bus.i_boot_size    = 32'h100;
    bus.i_core_addr[1] = 32'h1100;
    bus.i_core_req[1]  = 1'b1;
    b0 = boot_pulses;
    l2_serve({8{32'h0000_1100}}, 1, dv, av);
    chk("edge_addr",  256'(av), 256'(32'h1100));
    chk("edge_done",  256'(dv), 256'(4'b0010));
    chk("edge_noboot", 256'(boot_pulses - b0), 256'(0));
    bus.i_core_req[1] = 1'b0;
    tick();

    // Zero-sized boot window: even address 0 goes to L2
    bus.i_boot_base    = 32'h0;
    bus.i_boot_size    = 32'h0;
    bus.i_core_addr[1] = 32'h4;
    bus.i_core_req[1]  = 1'b1;
    b0 = boot_pulses;
    l2_serve({8{32'h0000_0004}}, 1, dv, av);
    chk("size0_addr",   256'(av), 256'(32'h0));
    chk("size0_done",   256'(dv), 256'(4'b0010));
    chk("size0_noboot", 256'(boot_pulses - b0), 256'(0));
    bus.i_core_req[1] = 1'b0;
    tick();

    // Reset in L2_WAIT aborts the transaction; a late L2 done is ignored
    bus.i_core_addr[2] = 32'h2000;
    bus.i_core_req[2]  = 1'b1;
    t = 0;
    while (!bus.o_l2_req && t < 10) begin
      tick();
      t++;
    end
    chk("abort_l2_up", 256'(bus.o_l2_req), 256'(1));
    tick();
    rst = 1'b1;
    bus.i_core_req[2] = 1'b0;
    #1;
    chk("abort_l2_req",  256'(bus.o_l2_req),      256'(0));
    chk("abort_l2_addr", 256'(bus.o_l2_addr),     256'(0));
    chk("abort_boot",    256'(bus.o_boot_addr),   256'(0));
    chk("abort_rdata",   256'(|bus.o_core_rdata), 256'(0));
    tick();
    rst = 1'b0;
    bus.i_l2_rdata = {8{32'hDEAD_BEEF}};
    bus.i_l2_done  = 1'b1;
    tick();
    bus.i_l2_done  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_no_done", 256'(bus.o_core_done), 256'(0));
      chk("abort_no_req",  256'(bus.o_l2_req),    256'(0));
    end

    // Cores 0 and 1 request the same line
    bus.i_core_addr[0] = 32'h5000_0004;
    bus.i_core_addr[1] = 32'h5000_0018;
    bus.i_core_req     = 4'b0011;
    l0 = l2_rises;
    d  = {8{32'h5A5A_0000}};
`ifdef ICARB_COALESCE_EN
    l2_serve(d, 1, dv, av);
    chk("coal_done",   256'(dv), 256'(4'b0011));
    chk("coal_rdata0", bus.o_core_rdata[0], d);
    chk("coal_rdata1", bus.o_core_rdata[1], d);
    bus.i_core_req = '0;
    tick(); tick(); tick();
    chk("coal_one_fetch", 256'(l2_rises - l0), 256'(1));
`else
    l2_serve(d, 1, dv, av);
    chk("same_first",  256'(dv), 256'(4'b0001));
    chk("same_rdata0", bus.o_core_rdata[0], d);
    bus.i_core_req[0] = 1'b0;
    l2_serve(d, 1, dv, av);
    chk("same_second", 256'(dv), 256'(4'b0010));
    chk("same_addr",   256'(av), 256'(32'h5000_0000));
    bus.i_core_req = '0;
    tick(); tick(); tick();
    chk("same_two_fetch", 256'(l2_rises - l0), 256'(2));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
